// File: rtl/ram_fifo_ctrl.sv
// First-word-fall-through FIFO controller around a simple dual-port block RAM with a 1-cycle read.
// A 2-entry output stage hides the read latency so a steady stream moves one word per clock.
module ram_fifo_ctrl #(
   parameter int WIDTH     = 4,
   parameter int DEPTH     = 256,
   parameter int ADDRWIDTH = 8
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_flush,
   input  logic                 i_in_valid,
   output logic                 o_in_ready,
   input  logic [WIDTH-1:0]     i_in_data,
   output logic                 o_out_valid,
   input  logic                 i_out_ready,
   output logic [WIDTH-1:0]     o_out_data,
   output logic [ADDRWIDTH:0]   o_count,
   output logic                 o_ram_ena,
   output logic                 o_ram_wea,
   output logic [ADDRWIDTH-1:0] o_ram_addra,
   output logic [WIDTH-1:0]     o_ram_dia,
   output logic                 o_ram_enb,
   output logic [ADDRWIDTH-1:0] o_ram_addrb,
   input  logic [WIDTH-1:0]     i_ram_dob
);

   localparam logic [ADDRWIDTH:0] DEPTH_C = (ADDRWIDTH+1)'(DEPTH);

   logic [ADDRWIDTH-1:0] r_wptr;
   logic [ADDRWIDTH-1:0] r_rptr;
   logic [ADDRWIDTH:0]   r_mem_cnt;
   logic                 r_pending;
   logic [WIDTH-1:0]     r_stage0;
   logic [WIDTH-1:0]     r_stage1;
   logic [1:0]           r_stage_cnt;
   logic [ADDRWIDTH:0]   r_count;

   logic                 w_clear;
   logic                 w_push;
   logic                 w_pop;
   logic                 w_issue;
   logic [2:0]           w_committed;
   logic [ADDRWIDTH:0]   w_mem_cnt_nxt;
   logic [1:0]           w_stage_cnt_nxt;
   logic [WIDTH-1:0]     w_stage0_nxt;
   logic [WIDTH-1:0]     w_stage1_nxt;
   logic [ADDRWIDTH:0]   w_count_nxt;

   // Reset and flush share one clear path; both also block the current push and read.
   assign w_clear     = !i_rst_n || i_flush;
   assign o_in_ready  = (r_mem_cnt < DEPTH_C) && !w_clear;
   assign w_push      = i_in_valid && o_in_ready;
   assign o_out_valid = (r_stage_cnt != 2'd0);
   assign o_out_data  = r_stage0;
   assign w_pop       = o_out_valid && i_out_ready;
   assign o_count     = r_count;

   assign o_ram_ena   = w_push;
   assign o_ram_wea   = w_push;
   assign o_ram_addra = r_wptr;
   assign o_ram_dia   = i_in_data;

   // Only read when the word has a guaranteed seat in the output stage.
   assign w_committed = {1'b0, r_stage_cnt} + {2'b00, r_pending} - {2'b00, w_pop};
   assign w_issue     = (r_mem_cnt != '0) && (w_committed < 3'd2) && !w_clear;
   assign o_ram_enb   = w_issue;
   assign o_ram_addrb = r_rptr;

   assign w_mem_cnt_nxt = r_mem_cnt + (ADDRWIDTH+1)'(w_push) - (ADDRWIDTH+1)'(w_issue);
   assign w_count_nxt   = w_mem_cnt_nxt + (ADDRWIDTH+1)'(w_issue) + (ADDRWIDTH+1)'(w_stage_cnt_nxt);

   always_comb begin
      w_stage_cnt_nxt = r_stage_cnt;
      w_stage0_nxt    = r_stage0;
      w_stage1_nxt    = r_stage1;
      if (w_pop) begin
         w_stage0_nxt    = r_stage1;
         w_stage_cnt_nxt = r_stage_cnt - 2'd1;
      end
      // Returning read data lands at the tail that remains after any pop.
      if (r_pending) begin
         if (w_stage_cnt_nxt == 2'd0) begin
            w_stage0_nxt = i_ram_dob;
         end else begin
            w_stage1_nxt = i_ram_dob;
         end
         w_stage_cnt_nxt = w_stage_cnt_nxt + 2'd1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_clear) begin
         r_wptr      <= '0;
         r_rptr      <= '0;
         r_mem_cnt   <= '0;
         r_pending   <= 1'b0;
         r_stage0    <= '0;
         r_stage1    <= '0;
         r_stage_cnt <= 2'd0;
         r_count     <= '0;
      end else begin
         if (w_push) begin
            r_wptr <= r_wptr + ADDRWIDTH'(1);
         end
         if (w_issue) begin
            r_rptr <= r_rptr + ADDRWIDTH'(1);
         end
         r_mem_cnt   <= w_mem_cnt_nxt;
         r_pending   <= w_issue;
         r_stage0    <= w_stage0_nxt;
         r_stage1    <= w_stage1_nxt;
         r_stage_cnt <= w_stage_cnt_nxt;
         r_count     <= w_count_nxt;
      end
   end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Directed bench for ram_fifo_ctrl with a behavioural block RAM (registered read) attached.
module tb_ram_fifo_ctrl;
   localparam int W = 4;
   localparam int D = 256;
   localparam int A = 8;

   logic         clk = 1'b0;
   logic         rst_n, flush, in_valid, in_ready, out_valid, out_ready;
   logic [W-1:0] in_data, out_data, ram_dia, ram_dob;
   logic [A:0]   count;
   logic         ram_ena, ram_wea, ram_enb;
   logic [A-1:0] ram_addra, ram_addrb;

   logic [W-1:0] mem [D];
   logic [W-1:0] exp_q [$];

   int checks = 0;
   int errors = 0;
   int tb_wr  = 0;

   always #5 clk = ~clk;

   ram_fifo_ctrl #(.WIDTH(W), .DEPTH(D), .ADDRWIDTH(A)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush),
      .i_in_valid(in_valid), .o_in_ready(in_ready), .i_in_data(in_data),
      .o_out_valid(out_valid), .i_out_ready(out_ready), .o_out_data(out_data),
      .o_count(count),
      .o_ram_ena(ram_ena), .o_ram_wea(ram_wea), .o_ram_addra(ram_addra), .o_ram_dia(ram_dia),
      .o_ram_enb(ram_enb), .o_ram_addrb(ram_addrb), .i_ram_dob(ram_dob)
   );

   always @(posedge clk) begin
      if (ram_ena && ram_wea) mem[ram_addra] <= ram_dia;
      if (ram_enb) ram_dob <= mem[ram_addrb];
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
      tick(); tick();
      rst_n = 1'b1;
      settle();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
      checks++; if (count !== 9'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
      checks++; if (out_data !== 4'h0) begin errors++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
      checks++; if ({ram_ena, ram_enb} !== 2'b00) begin errors++; $display("FAIL reset_ram_en got=%b exp=00", {ram_ena, ram_enb}); end
      tick();
      tb_wr = 0;
   endtask

   task automatic test_single();
      in_valid = 1'b1; in_data = 4'hA; out_ready = 1'b1;
      settle();
      checks++; if ({ram_ena, ram_wea, ram_addra, ram_dia} !== {2'b11, 8'd0, 4'hA}) begin
         errors++; $display("FAIL single_write got=%b/%b/%0d/%h exp=1/1/0/a", ram_ena, ram_wea, ram_addra, ram_dia);
      end
      tick();
      in_valid = 1'b0;
      settle();
      checks++; if ({ram_enb, ram_addrb} !== {1'b1, 8'd0}) begin errors++; $display("FAIL single_issue got=%b/%0d exp=1/0", ram_enb, ram_addrb); end
      checks++; if (count !== 9'd1) begin errors++; $display("FAIL single_count_c1 got=%0d exp=1", count); end
      tick(); settle();
      checks++; if (out_valid !== 1'b0 || count !== 9'd1) begin errors++; $display("FAIL single_c2 got=%b/%0d exp=0/1", out_valid, count); end
      tick(); settle();
      checks++; if (out_valid !== 1'b1 || out_data !== 4'hA) begin errors++; $display("FAIL single_out got=%b/%h exp=1/a", out_valid, out_data); end
      tick(); settle();
      checks++; if (count !== 9'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL single_drained got=%0d/%b exp=0/0", count, out_valid); end
      tick();
      tb_wr = 1;
   endtask

   task automatic test_fill();
      int bad = 0, got = 0, bubbles = 0, cyc = 0;
      out_ready = 1'b0;
      for (int i = 0; i < 258; i++) begin
         in_valid = 1'b1; in_data = W'(i % 16);
         settle();
         if (in_ready !== 1'b1) bad++;
         tick();
      end
      tb_wr = (tb_wr + 258) % D;
      checks++; if (bad != 0) begin errors++; $display("FAIL fill_ready got=%0d refusals exp=0", bad); end
      in_data = 4'h0;
      settle();
      checks++; if (in_ready !== 1'b0 || ram_ena !== 1'b0) begin errors++; $display("FAIL full_ready got=%b/%b exp=0/0", in_ready, ram_ena); end
      checks++; if (count !== 9'd258) begin errors++; $display("FAIL full_count got=%0d exp=258", count); end
      tick();
      in_valid = 1'b0;
      tick(); settle();
      checks++; if (count !== 9'd258) begin errors++; $display("FAIL full_hold_count got=%0d exp=258", count); end
      out_ready = 1'b1;
      bad = 0;
      while (got < 258 && cyc < 400) begin
         settle();
         if (out_valid === 1'b1) begin
            if (out_data !== W'(got % 16)) bad++;
            got++;
         end else begin
            bubbles++;
         end
         tick();
         cyc++;
      end
      checks++; if (got != 258) begin errors++; $display("FAIL drain_words got=%0d exp=258", got); end
      checks++; if (bad != 0) begin errors++; $display("FAIL drain_order got=%0d wrong exp=0", bad); end
      checks++; if (bubbles != 0) begin errors++; $display("FAIL drain_bubbles got=%0d exp=0", bubbles); end
      out_ready = 1'b0;
      settle();
      checks++; if (count !== 9'd0) begin errors++; $display("FAIL drain_count got=%0d exp=0", count); end
      tick();
   endtask

   task automatic test_stream();
      int sent = 0, got = 0, first = -1, bubbles = 0, bad = 0, cyc = 0;
      logic [W-1:0] e;
      out_ready = 1'b1;
      while (got < 1000 && cyc < 1100) begin
         in_valid = (sent < 1000);
         in_data  = W'((sent * 7 + 3) % 16);
         settle();
         if (in_valid && in_ready) begin exp_q.push_back(in_data); sent++; end
         if (out_valid === 1'b1) begin
            if (first < 0) first = cyc;
            if (exp_q.size() == 0) bad++;
            else begin e = exp_q.pop_front(); if (out_data !== e) bad++; end
            got++;
         end else if (first >= 0) begin
            bubbles++;
         end
         tick();
         cyc++;
      end
      in_valid = 1'b0;
      tb_wr = (tb_wr + 1000) % D;
      settle();
      checks++; if (got != 1000) begin errors++; $display("FAIL stream_words got=%0d exp=1000", got); end
      checks++; if (bad != 0) begin errors++; $display("FAIL stream_data got=%0d wrong exp=0", bad); end
      checks++; if (first != 3) begin errors++; $display("FAIL stream_latency got=%0d exp=3", first); end
      checks++; if (bubbles != 0) begin errors++; $display("FAIL stream_bubbles got=%0d exp=0", bubbles); end
      checks++; if (ram_addra !== A'(tb_wr) || ram_addrb !== A'(tb_wr)) begin
         errors++; $display("FAIL stream_wrap_ptrs got=%0d/%0d exp=%0d", ram_addra, ram_addrb, tb_wr);
      end
      exp_q.delete();
      tick();
   endtask

   task automatic test_backpressure();
      int held = 0, bad_cnt = 0, bad_data = 0, bad_full = 0, saw_full = 0, cyc = 0;
      logic [W-1:0] e;
      for (int c = 0; c < 5000; c++) begin
         in_valid  = ($urandom_range(0, 99) < 70);
         out_ready = ($urandom_range(0, 99) < 30);
         in_data   = W'($urandom_range(0, 15));
         settle();
         if (count !== (A+1)'(held)) bad_cnt++;
         if (in_ready === 1'b0) begin saw_full++; if (held != D + 2) bad_full++; end
         if (in_valid && in_ready) begin exp_q.push_back(in_data); held++; end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) bad_data++;
            else begin e = exp_q.pop_front(); if (out_data !== e) bad_data++; end
            held--;
         end
         tick();
      end
      in_valid = 1'b0; out_ready = 1'b1;
      while (exp_q.size() > 0 && cyc < 400) begin
         settle();
         if (out_valid === 1'b1) begin e = exp_q.pop_front(); if (out_data !== e) bad_data++; end
         tick();
         cyc++;
      end
      settle();
      checks++; if (bad_data != 0) begin errors++; $display("FAIL bp_data got=%0d wrong exp=0", bad_data); end
      checks++; if (bad_cnt != 0) begin errors++; $display("FAIL bp_count got=%0d wrong cycles exp=0", bad_cnt); end
      checks++; if (bad_full != 0 || saw_full == 0) begin errors++; $display("FAIL bp_full got=%0d bad/%0d full cycles exp=0/>0", bad_full, saw_full); end
      checks++; if (exp_q.size() != 0 || count !== 9'd0) begin errors++; $display("FAIL bp_drain got=%0d left/count %0d exp=0/0", exp_q.size(), count); end
      exp_q.delete();
      out_ready = 1'b0;
      tick();
   endtask

   task automatic test_mid_clear(input bit use_reset);
      int bad = 0;
      string nm;
      nm = use_reset ? "rst" : "flush";
      out_ready = 1'b0;
      for (int i = 0; i < 12; i++) begin
         in_valid = 1'b1; in_data = W'(i + 1);
         settle(); tick();
      end
      in_valid = 1'b0;
      tick(); tick(); tick();
      settle();
      checks++; if (count !== 9'd12) begin errors++; $display("FAIL %s_prefill got=%0d exp=12", nm, count); end
      out_ready = 1'b1;
      settle();
      checks++; if (out_valid !== 1'b1 || ram_enb !== 1'b1) begin errors++; $display("FAIL %s_pop_issue got=%b/%b exp=1/1", nm, out_valid, ram_enb); end
      tick();
      out_ready = 1'b0; in_valid = 1'b1; in_data = 4'hF;
      if (use_reset) rst_n = 1'b0; else flush = 1'b1;
      settle();
      checks++; if ({in_ready, ram_ena, ram_enb} !== 3'b000) begin errors++; $display("FAIL %s_suppress got=%b exp=000", nm, {in_ready, ram_ena, ram_enb}); end
      tick();
      rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0;
      settle();
      checks++; if (count !== 9'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL %s_cleared got=%0d/%b exp=0/0", nm, count, out_valid); end
      for (int k = 0; k < 3; k++) begin
         tick(); settle();
         if (out_valid !== 1'b0 || count !== 9'd0) bad++;
      end
      checks++; if (bad != 0) begin errors++; $display("FAIL %s_stale got=%0d cycles exp=0", nm, bad); end
      in_valid = 1'b1; in_data = 4'h5;
      settle();
      checks++; if (ram_ena !== 1'b1 || ram_addra !== 8'd0) begin errors++; $display("FAIL %s_wptr got=%b/%0d exp=1/0", nm, ram_ena, ram_addra); end
      tick();
      in_valid = 1'b0;
      tick(); tick(); settle();
      checks++; if (out_valid !== 1'b1 || out_data !== 4'h5) begin errors++; $display("FAIL %s_repush got=%b/%h exp=1/5", nm, out_valid, out_data); end
      out_ready = 1'b1;
      tick(); settle();
      checks++; if (count !== 9'd0) begin errors++; $display("FAIL %s_final_count got=%0d exp=0", nm, count); end
      out_ready = 1'b0;
      tick();
   endtask

   initial begin
      test_reset();
      test_single();
      test_fill();
      test_stream();
      test_backpressure();
      test_mid_clear(1'b0);
      test_mid_clear(1'b1);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
